// File: rtl/titan_pkg.sv
// Shared definitions for the Titan fetch path: exception causes, the NOP word,
// fetch FSM state encoding and the presented-instruction bundle.
// No logic; imported by titan_if_pcgen and titan_if_stage.
package titan_pkg;

  localparam logic [3:0]  EXC_INST_MISALIGN = 4'd0;
  localparam logic [3:0]  EXC_INST_FAULT    = 4'd1;
  localparam logic [31:0] NOP_INST          = 32'h0000_0033;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_KILL  = 2'd2
  } fetch_state_t;

  // Everything the IF/ID register sees for one instruction slot.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        trap_valid;
    logic [3:0]  exception;
    logic [31:0] exc_data;
  } fetch_out_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/titan_if_pcgen.sv
// PC generator: PC register, +4 incrementer, trap-over-branch redirect mux and
// the target latched while an orphaned request drains.
// Latency: new PC visible the cycle after advance/jump; redirect mux is combinational.
// Optional: TITAN_IF_MISALIGN_CHECK_EN keeps target[1:0] so the stage can fault on it.
module titan_if_pcgen
  import titan_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_target,
  input  logic        advance,
  input  logic        jump,
  input  logic        use_latched,
  input  logic        latch,
  output logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] jump_addr
);

  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] redir_raw;
  logic [31:0] redir_target;

  assign redirect  = br_taken | trap_taken;
  assign redir_raw = trap_taken ? trap_target : br_target;

`ifdef TITAN_IF_MISALIGN_CHECK_EN
  assign redir_target = redir_raw;
`else
  assign redir_target = word_align(redir_raw);
`endif

  // A drained kill restarts from the latched target; otherwise the live redirect.
  assign jump_addr = use_latched ? tgt_q : redir_target;
  assign pc        = pc_q;

  // PC update (wraps modulo 2^32) and target capture while killing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_ADDR;
      tgt_q <= RESET_ADDR;
    end else begin
      if (jump) begin
        pc_q <= jump_addr;
      end else if (advance) begin
        pc_q <= pc_q + 32'd4;
      end
      if (latch) begin
        tgt_q <= redir_target;
      end
    end
  end

endmodule

// File: rtl/titan_if_stage.sv
// Instruction fetch: owns the PC, runs one-outstanding word fetches, feeds IF/ID.
// Latency: zero-wait ack presents the word in the same cycle, 1 instr/cycle sustained.
// Backpressure: if_stall parks a returned word in a hold buffer and drops the bus request.
// Optional: TITAN_IF_MISALIGN_CHECK_EN raises a misaligned-fetch exception on redirect.
module titan_if_stage
  import titan_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter logic [31:0] NOP_INST   = titan_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_target,
  output logic [31:0] iport_addr,
  output logic        iport_cyc,
  output logic        iport_stb,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack,
  input  logic        iport_err,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [3:0]  if_exception,
  output logic        if_trap_valid,
  output logic [31:0] if_exc_data,
  output logic        if_stall_req
);

  fetch_state_t state;
  logic         cyc_q;
  fetch_out_t   hold_q;
  fetch_out_t   fetch_word;
  fetch_out_t   misalign_word;
  fetch_out_t   present;

  logic [31:0] pc;
  logic [31:0] jump_addr;
  logic        redirect;
  logic        resp;
  logic        is_err;
  logic        pending;
  logic        latch;
  logic        use_latched;
  logic        jump;
  logic        advance;
  logic        jump_mis;
  logic        out_valid;

  // Responses only count while our request is on the bus; err wins over ack.
  assign resp    = cyc_q & (iport_ack | iport_err);
  assign is_err  = cyc_q & iport_err;
  assign pending = cyc_q & ~resp;

  // A redirect that finds a request still in flight must drain it first.
  assign latch       = redirect & pending;
  assign use_latched = (state == S_KILL) & resp & ~redirect;
  assign jump        = (redirect & ~pending) | use_latched;
  assign advance     = ~redirect & ~if_stall &
                       (((state == S_FETCH) & resp) | (state == S_HOLD));

`ifdef TITAN_IF_MISALIGN_CHECK_EN
  assign jump_mis = (jump_addr[1:0] != 2'b00);
`else
  assign jump_mis = 1'b0;
`endif

  titan_if_pcgen #(
    .RESET_ADDR (RESET_ADDR)
  ) u_pcgen (
    .clk         (clk),
    .rst         (rst),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .trap_taken  (trap_taken),
    .trap_target (trap_target),
    .advance     (advance),
    .jump        (jump),
    .use_latched (use_latched),
    .latch       (latch),
    .pc          (pc),
    .redirect    (redirect),
    .jump_addr   (jump_addr)
  );

  // Word as returned by the bus this cycle, with fault information folded in.
  always_comb begin
    fetch_word.pc         = pc;
    fetch_word.inst       = is_err ? NOP_INST : iport_data_i;
    fetch_word.trap_valid = is_err;
    fetch_word.exception  = is_err ? EXC_INST_FAULT : 4'd0;
    fetch_word.exc_data   = is_err ? pc : 32'd0;
  end

  // Synthetic slot for a redirect to a non-word-aligned target.
  always_comb begin
    misalign_word.pc         = jump_addr;
    misalign_word.inst       = NOP_INST;
    misalign_word.trap_valid = 1'b1;
    misalign_word.exception  = EXC_INST_MISALIGN;
    misalign_word.exc_data   = jump_addr;
  end

  // A redirect squashes whatever would have been presented this cycle.
  assign out_valid = ~redirect & (((state == S_FETCH) & resp) | (state == S_HOLD));

  // Select the presented slot; an empty slot is a clean NOP with no trap.
  always_comb begin
    present.pc         = 32'd0;
    present.inst       = NOP_INST;
    present.trap_valid = 1'b0;
    present.exception  = 4'd0;
    present.exc_data   = 32'd0;
    if (out_valid) begin
      present = (state == S_HOLD) ? hold_q : fetch_word;
    end
  end

  assign iport_addr    = word_align(pc);
  assign iport_cyc     = cyc_q;
  assign iport_stb     = cyc_q;
  assign if_pc         = present.pc;
  assign if_inst       = present.inst;
  assign if_trap_valid = present.trap_valid;
  assign if_exception  = present.exception;
  assign if_exc_data   = present.exc_data;
  assign if_stall_req  = ~out_valid;

  // Fetch FSM with registered bus request and hold buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FETCH;
      cyc_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      cyc_q <= (state != S_HOLD);
      if (jump) begin
        if (jump_mis) begin
          state  <= S_HOLD;
          cyc_q  <= 1'b0;
          hold_q <= misalign_word;
        end else begin
          state <= S_FETCH;
          cyc_q <= 1'b1;
        end
      end else if (latch) begin
        state <= S_KILL;
        cyc_q <= 1'b1;
      end else if ((state == S_FETCH) && resp && if_stall) begin
        state  <= S_HOLD;
        cyc_q  <= 1'b0;
        hold_q <= fetch_word;
      end else if ((state == S_HOLD) && !if_stall) begin
        state <= S_FETCH;
        cyc_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_titan_if_stage.sv
// Self-checking bench for titan_if_stage: directed scenarios plus a randomized
// run scored against an architectural model (expected next PC of the instruction
// stream, redirects override it, accepted slots must match memory or a fault).
module tb_titan_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_taken;
  logic [31:0] trap_target;
  logic [31:0] iport_addr;
  logic        iport_cyc;
  logic        iport_stb;
  logic [31:0] iport_data_i;
  logic        iport_ack;
  logic        iport_err;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [3:0]  if_exception;
  logic        if_trap_valid;
  logic [31:0] if_exc_data;
  logic        if_stall_req;

  int total  = 0;
  int passed = 0;

  // Slave configuration and state.
  int          slave_delay = 0;
  bit          slave_rand  = 0;
  bit          err_rand    = 0;
  bit          both_on_err = 0;
  logic [31:0] err_addr    = 32'h1;
  bit          pend        = 0;
  int          cnt         = 0;
  logic [31:0] paddr       = 32'h0;

  always #5 clk = ~clk;

  titan_if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .if_stall     (if_stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap_taken   (trap_taken),
    .trap_target  (trap_target),
    .iport_addr   (iport_addr),
    .iport_cyc    (iport_cyc),
    .iport_stb    (iport_stb),
    .iport_data_i (iport_data_i),
    .iport_ack    (iport_ack),
    .iport_err    (iport_err),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_exception (if_exception),
    .if_trap_valid(if_trap_valid),
    .if_exc_data  (if_exc_data),
    .if_stall_req (if_stall_req)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit is_err_addr(input logic [31:0] a);
    if (err_rand) return (a[6:2] == 5'd7);
    return (a == err_addr);
  endfunction

  // Advance to just after the next rising edge and drive the slave response.
  task automatic tick();
    @(posedge clk);
    #1;
    if (iport_cyc && iport_stb) begin
      if (!pend) begin
        pend  = 1;
        paddr = iport_addr;
        cnt   = slave_rand ? int'($urandom_range(0, 2)) : slave_delay;
      end else begin
        total++;
        if (iport_addr !== paddr) $display("FAIL addr_hold: got %h want %h", iport_addr, paddr);
        else passed++;
      end
      iport_data_i = mem(iport_addr);
      if (cnt == 0) begin
        pend = 0;
        if (is_err_addr(iport_addr)) begin
          iport_err = 1'b1;
          iport_ack = err_rand ? 1'($urandom_range(0, 1)) : both_on_err;
        end else begin
          iport_err = 1'b0;
          iport_ack = 1'b1;
        end
      end else begin
        cnt--;
        iport_ack = 1'b0;
        iport_err = 1'b0;
      end
    end else begin
      pend      = 0;
      iport_ack = 1'b0;
      iport_err = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    if_stall     = 1'b0;
    br_taken     = 1'b0;
    br_target    = 32'h0;
    trap_taken   = 1'b0;
    trap_target  = 32'h0;
    iport_ack    = 1'b0;
    iport_err    = 1'b0;
    iport_data_i = 32'h0;
    pend         = 0;
  endtask

  // Leaves the caller just after the edge that precedes the first request cycle.
  task automatic reset_dut();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    slave_delay = 0;
  endtask

  task automatic run_until(input logic [31:0] a, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (iport_cyc && iport_addr == a) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    total++; if (iport_cyc !== 1'b0) $display("FAIL rst_cyc: got %b want 0", iport_cyc); else passed++;
    total++; if (iport_stb !== 1'b0) $display("FAIL rst_stb: got %b want 0", iport_stb); else passed++;
    total++; if (if_inst !== NOP) $display("FAIL rst_inst: got %h want %h", if_inst, NOP); else passed++;
    total++; if (if_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", if_pc); else passed++;
    total++; if (if_exception !== 4'h0) $display("FAIL rst_exc: got %h want 0", if_exception); else passed++;
    total++; if (if_trap_valid !== 1'b0) $display("FAIL rst_trap: got %b want 0", if_trap_valid); else passed++;
    total++; if (if_exc_data !== 32'h0) $display("FAIL rst_excdata: got %h want 0", if_exc_data); else passed++;
    total++; if (if_stall_req !== 1'b1) $display("FAIL rst_stallreq: got %b want 1", if_stall_req); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++; if (iport_stb !== 1'b1) $display("FAIL first_req_stb: got %b want 1", iport_stb); else passed++;
    total++; if (iport_addr !== 32'h8000_0000) $display("FAIL first_req_addr: got %h want 80000000", iport_addr); else passed++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp;
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      exp = 32'h8000_0000 + 32'(k * 4);
      tick();
      @(negedge clk);
      total++; if (iport_addr !== exp) $display("FAIL zw_addr[%0d]: got %h want %h", k, iport_addr, exp); else passed++;
      total++; if (if_stall_req !== 1'b0) $display("FAIL zw_stallreq[%0d]: got %b want 0", k, if_stall_req); else passed++;
      total++; if (if_inst !== mem(exp)) $display("FAIL zw_inst[%0d]: got %h want %h", k, if_inst, mem(exp)); else passed++;
      total++; if (if_pc !== exp) $display("FAIL zw_pc[%0d]: got %h want %h", k, if_pc, exp); else passed++;
    end
  endtask

  task automatic test_stall_hold();
    reset_dut();
    tick();
    tick();
    if_stall = 1'b1;
    @(negedge clk);
    total++; if (if_pc !== 32'h8000_0004) $display("FAIL st_pc0: got %h want 80000004", if_pc); else passed++;
    total++; if (if_inst !== mem(32'h8000_0004)) $display("FAIL st_inst0: got %h want %h", if_inst, mem(32'h8000_0004)); else passed++;
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      total++; if (iport_stb !== 1'b0) $display("FAIL st_stb[%0d]: got %b want 0", k, iport_stb); else passed++;
      total++; if (if_pc !== 32'h8000_0004) $display("FAIL st_pc[%0d]: got %h want 80000004", k, if_pc); else passed++;
      total++; if (if_inst !== mem(32'h8000_0004)) $display("FAIL st_inst[%0d]: got %h want %h", k, if_inst, mem(32'h8000_0004)); else passed++;
      total++; if (if_stall_req !== 1'b0) $display("FAIL st_stallreq[%0d]: got %b want 0", k, if_stall_req); else passed++;
    end
    tick();
    if_stall = 1'b0;
    @(negedge clk);
    total++; if (iport_stb !== 1'b0) $display("FAIL st_release_stb: got %b want 0", iport_stb); else passed++;
    total++; if (if_pc !== 32'h8000_0004) $display("FAIL st_release_pc: got %h want 80000004", if_pc); else passed++;
    tick();
    @(negedge clk);
    total++; if (iport_stb !== 1'b1) $display("FAIL st_reissue_stb: got %b want 1", iport_stb); else passed++;
    total++; if (iport_addr !== 32'h8000_0008) $display("FAIL st_reissue_addr: got %h want 80000008", iport_addr); else passed++;
  endtask

  task automatic test_redirect_kill();
    reset_dut();
    slave_delay = 2;
    tick();
    br_taken  = 1'b1;
    br_target = 32'h8000_0100;
    @(negedge clk);
    total++; if (if_stall_req !== 1'b1) $display("FAIL kill_redir_stallreq: got %b want 1", if_stall_req); else passed++;
    for (int k = 0; k < 2; k++) begin
      tick();
      br_taken = 1'b0;
      @(negedge clk);
      total++; if (iport_addr !== 32'h8000_0000) $display("FAIL kill_addr[%0d]: got %h want 80000000", k, iport_addr); else passed++;
      total++; if (if_stall_req !== 1'b1) $display("FAIL kill_stallreq[%0d]: got %b want 1", k, if_stall_req); else passed++;
    end
    slave_delay = 0;
    tick();
    @(negedge clk);
    total++; if (iport_addr !== 32'h8000_0100) $display("FAIL kill_new_addr: got %h want 80000100", iport_addr); else passed++;
    total++; if (if_pc !== 32'h8000_0100) $display("FAIL kill_new_pc: got %h want 80000100", if_pc); else passed++;
    total++; if (if_inst !== mem(32'h8000_0100)) $display("FAIL kill_new_inst: got %h want %h", if_inst, mem(32'h8000_0100)); else passed++;
  endtask

  task automatic test_priority();
    tick();
    trap_taken  = 1'b1;
    trap_target = 32'h8000_0200;
    br_taken    = 1'b1;
    br_target   = 32'h8000_0100;
    @(negedge clk);
    total++; if (if_stall_req !== 1'b1) $display("FAIL prio_stallreq: got %b want 1", if_stall_req); else passed++;
    tick();
    trap_taken = 1'b0;
    br_taken   = 1'b0;
    @(negedge clk);
    total++; if (iport_addr !== 32'h8000_0200) $display("FAIL prio_addr: got %h want 80000200", iport_addr); else passed++;
    total++; if (if_pc !== 32'h8000_0200) $display("FAIL prio_pc: got %h want 80000200", if_pc); else passed++;
  endtask

  task automatic test_fetch_err();
    bit ok;
    reset_dut();
    err_addr    = 32'h8000_0010;
    both_on_err = 1;
    run_until(32'h8000_0010, ok);
    total++;
    if (!ok) $display("FAIL err_reach: request to 80000010 not seen within 20 cycles");
    else begin
      passed++;
      @(negedge clk);
      total++; if (if_trap_valid !== 1'b1) $display("FAIL err_trap: got %b want 1", if_trap_valid); else passed++;
      total++; if (if_exception !== 4'd1) $display("FAIL err_exc: got %h want 1", if_exception); else passed++;
      total++; if (if_exc_data !== 32'h8000_0010) $display("FAIL err_excdata: got %h want 80000010", if_exc_data); else passed++;
      total++; if (if_inst !== NOP) $display("FAIL err_inst: got %h want %h", if_inst, NOP); else passed++;
      total++; if (if_stall_req !== 1'b0) $display("FAIL err_stallreq: got %b want 0", if_stall_req); else passed++;
      tick();
      @(negedge clk);
      total++; if (if_trap_valid !== 1'b0) $display("FAIL err_next_trap: got %b want 0", if_trap_valid); else passed++;
      total++; if (if_pc !== 32'h8000_0014) $display("FAIL err_next_pc: got %h want 80000014", if_pc); else passed++;
    end
    err_addr    = 32'h1;
    both_on_err = 0;
  endtask

  task automatic test_misalign();
    reset_dut();
    tick();
    br_taken  = 1'b1;
    br_target = 32'h8000_0102;
    @(negedge clk);
    tick();
    br_taken = 1'b0;
    @(negedge clk);
`ifdef TITAN_IF_MISALIGN_CHECK_EN
    total++; if (iport_stb !== 1'b0) $display("FAIL mis_stb: got %b want 0", iport_stb); else passed++;
    total++; if (if_stall_req !== 1'b0) $display("FAIL mis_stallreq: got %b want 0", if_stall_req); else passed++;
    total++; if (if_trap_valid !== 1'b1) $display("FAIL mis_trap: got %b want 1", if_trap_valid); else passed++;
    total++; if (if_exception !== 4'd0) $display("FAIL mis_exc: got %h want 0", if_exception); else passed++;
    total++; if (if_exc_data !== 32'h8000_0102) $display("FAIL mis_excdata: got %h want 80000102", if_exc_data); else passed++;
    total++; if (if_inst !== NOP) $display("FAIL mis_inst: got %h want %h", if_inst, NOP); else passed++;
`else
    total++; if (iport_stb !== 1'b1) $display("FAIL mis_stb: got %b want 1", iport_stb); else passed++;
    total++; if (iport_addr !== 32'h8000_0100) $display("FAIL mis_addr: got %h want 80000100", iport_addr); else passed++;
    total++; if (if_trap_valid !== 1'b0) $display("FAIL mis_trap: got %b want 0", if_trap_valid); else passed++;
    total++; if (if_pc !== 32'h8000_0100) $display("FAIL mis_pc: got %h want 80000100", if_pc); else passed++;
`endif
  endtask

  task automatic test_wrap();
    reset_dut();
    tick();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    tick();
    br_taken = 1'b0;
    @(negedge clk);
    total++; if (iport_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", iport_addr); else passed++;
    total++; if (if_inst !== mem(32'hFFFF_FFFC)) $display("FAIL wrap_inst0: got %h want %h", if_inst, mem(32'hFFFF_FFFC)); else passed++;
    tick();
    @(negedge clk);
    total++; if (iport_addr !== 32'h0) $display("FAIL wrap_addr1: got %h want 0", iport_addr); else passed++;
    total++; if (if_pc !== 32'h0) $display("FAIL wrap_pc1: got %h want 0", if_pc); else passed++;
  endtask

  // Random bus timing, faults, stalls and redirects against the program-order model.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [68:0] got;
    logic [68:0] want;
    int accepted;
    reset_dut();
    slave_rand = 1;
    err_rand   = 1;
    exp_pc     = 32'h8000_0000;
    accepted   = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if_stall    = ($urandom_range(0, 3) == 0);
      trap_taken  = ($urandom_range(0, 19) == 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      trap_target = 32'h8000_0000 + 32'($urandom_range(0, 63) * 4);
      br_target   = 32'h8000_0000 + 32'($urandom_range(0, 63) * 4);
      @(negedge clk);
      if (trap_taken || br_taken) begin
        total++; if (if_stall_req !== 1'b1) $display("FAIL rnd_redir_stallreq c=%0d: got %b want 1", c, if_stall_req); else passed++;
        exp_pc = trap_taken ? trap_target : br_target;
      end else if (!if_stall_req && !if_stall) begin
        total++; if (if_pc !== exp_pc) $display("FAIL rnd_pc c=%0d: got %h want %h", c, if_pc, exp_pc); else passed++;
        got = {if_inst, if_trap_valid, if_exception, if_exc_data};
        if (exp_pc[6:2] == 5'd7) want = {NOP, 1'b1, 4'd1, exp_pc};
        else want = {mem(exp_pc), 1'b0, 4'd0, 32'h0};
        total++; if (got !== want) $display("FAIL rnd_slot c=%0d: got %h want %h", c, got, want); else passed++;
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
    end
    total++; if (accepted < 60) $display("FAIL rnd_progress: got %0d accepted want at least 60", accepted); else passed++;
    slave_rand = 0;
    err_rand   = 0;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_kill();
    test_priority();
    test_fetch_err();
    test_misalign();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
